data_mem_lsu: RTL and testbench
===============================

Name: data_mem_lsu

Overview:
- Parametrised successor to the team's single-cycle data memory.
- Provides a byte-addressed data memory with byte, half, word and optional dword access, sign or zero extension, and write byte-masking.
- Adds misalignment and range error detection, a configurable read latency, and a valid/ready request/response handshake.
- Sits between the core's load/store unit and the data array; at most one request is outstanding at a time.

Parameters:
- DATA_W, 32: data width in bits. Legal values are 32 or 64.
- DEPTH, 32: number of DATA_W-bit words.
- ADDR_W, 32: width of the byte address.
- READ_LAT, 1: cycles from request acceptance to rsp_valid. Legal range is 1 to 4.

Ports:
- clk, in, 1: clock; all state updates on its rising edge.
- rst, in, 1: reset, asynchronous and active-high.
- req_valid, in, 1: request present.
- req_ready, out, 1: block can accept a request.
- req_we, in, 1: 1 = store, 0 = load.
- req_size, in, 2: 0 = byte, 1 = half, 2 = word, 3 = dword.
- req_unsigned, in, 1: load zero-extends when 1, sign-extends when 0.
- req_addr, in, ADDR_W: byte address.
- req_wdata, in, DATA_W: store data, right-aligned (LSBs).
- rsp_valid, out, 1: response present.
- rsp_ready, in, 1: consumer accepts the response.
- rsp_rdata, out, DATA_W: extended load data; 0 for stores and for errors.
- rsp_err, out, 1: access was misaligned, out of range, or had an illegal size.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, latency counter = 0.
  - req_ready = 0 while rst is high, then 1 in IDLE.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Memory array contents are not reset.
- States:
  - IDLE: req_ready = 1.
  - BUSY: latency counting.
  - RESP: rsp_valid = 1.
- Transitions:
  - IDLE to BUSY on the rising edge where req_valid && req_ready.
  - BUSY to RESP when the counter reaches READ_LAT-1. With READ_LAT = 1, BUSY lasts 0 cycles, so the block goes IDLE to RESP directly.
  - RESP to IDLE on the rising edge where rsp_ready = 1. rsp_valid stays high and the response stays stable until then.
- Latency and throughput:
  - rsp_valid rises exactly READ_LAT cycles after the acceptance edge.
  - No new request is accepted until the response handshake completes. Peak throughput is one request per READ_LAT+1 cycles.
- Address decode:
  - word index = req_addr >> log2(DATA_W/8).
  - byte offset = the low log2(DATA_W/8) bits of req_addr.
- Errors:
  - Misaligned if the byte offset is not a multiple of the access size in bytes.
  - Out of range if word index >= DEPTH.
  - Illegal size if req_size = 3 and DATA_W = 32.
  - On any error: memory is unchanged, rsp_err = 1, rsp_rdata = 0.
- Store:
  - Performed at the acceptance edge.
  - Only the selected bytes are written; the low size-bytes of req_wdata go to byte lanes starting at the byte offset.
  - Other lanes keep their old value.
- Load:
  - The word is sampled at the acceptance edge and held internally. Later stores cannot occur before the response, so there is no hazard.
  - Selected bytes are shifted to the LSBs.
  - Upper bits are sign-extended from the MSB of the accessed field, or zero-filled when req_unsigned = 1.
- Store response: rsp_rdata = 0, rsp_err = 0 when legal.
- Request inputs are sampled only at acceptance; they are don't-care otherwise.
- If rst asserts mid-transaction (BUSY or RESP):
  - The transaction is dropped and the response is never presented.
  - A store already accepted remains written.
- rsp_ready held high in IDLE has no effect.

Test Plan:
- Little-endian byte placement, DATA_W = 32, READ_LAT = 1:
  - Store word 0x8899AABB to address 0x8, then load byte unsigned at 0xA.
  - Required: rsp_rdata = 0x00000099, rsp_valid 1 cycle after acceptance.
  - Load byte signed at 0xA: rsp_rdata = 0xFFFFFF99.
- Masked store:
  - Word 0x11223344 at 0x4, then store half 0xBEEF at 0x6.
  - Load word at 0x4 returns 0xBEEF3344.
  - Load half signed at 0x6 returns 0xFFFFBEEF.
- Errors:
  - Load word at 0x5 gives rsp_err = 1, rsp_rdata = 0.
  - Store at 0x80 (index 32, DEPTH 32) gives rsp_err = 1, and a later read of index 31 is unchanged.
  - req_size = 3 with DATA_W = 32 gives rsp_err = 1.
- Latency and backpressure, READ_LAT = 3:
  - Accept a load at cycle 0; rsp_valid rises at cycle 3.
  - Hold rsp_ready = 0 for 4 cycles: rsp_rdata is stable, req_ready = 0, and a new req_valid is ignored.
  - rsp_ready = 1 at cycle 7: back in IDLE at cycle 8, req_ready = 1.
- Reset mid-operation, READ_LAT = 3:
  - Assert rst asynchronously in the BUSY state: rsp_valid = 0 and req_ready = 0 immediately.
  - After release, the block is in IDLE and the dropped response never appears.
- DATA_W = 64:
  - Store dword 0x0123456789ABCDEF at 0x10.
  - Load word signed at 0x14 returns 0x0000000001234567.
  - Load word signed at 0x10 returns 0xFFFFFFFF89ABCDEF.

Source files
------------

// File: rtl/data_mem_lsu_if.sv
// Request/response bundle between the load/store unit and the data memory.
// The master side issues requests and consumes responses.
interface data_mem_lsu_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid,
        output req_we,
        output req_size,
        output req_unsigned,
        output req_addr,
        output req_wdata,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_size,
        input  req_unsigned,
        input  req_addr,
        input  req_wdata,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err
    );
endinterface

// File: rtl/data_mem_lsu.sv
// Byte-addressed data memory with sized/extended access, error detection,
// configurable read latency and a single-outstanding valid/ready handshake.
module data_mem_lsu #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 32,
    parameter int READ_LAT = 1
) (
    input logic           clk,
    input logic           rst,
    data_mem_lsu_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] LAST = 3'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t state, state_d;
    logic [2:0] cnt, cnt_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [OFF_W-1:0]  off;
    logic [OFF_W-1:0]  amask;
    logic [ADDR_W-1:0] idx;
    logic [IDX_W-1:0]  widx;
    logic [3:0]        nbytes;
    logic [6:0]        nbits;
    logic              mis;
    logic              oor;
    logic              bad_size;
    logic              err;
    logic              acc;
    logic [NB-1:0]     lanes;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wsh;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] fmask;
    logic [DATA_W-1:0] msb;
    logic [DATA_W-1:0] ext;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    assign off      = bus.req_addr[OFF_W-1:0];
    assign idx      = bus.req_addr >> OFF_W;
    assign widx     = idx[IDX_W-1:0];
    assign nbytes   = 4'd1 << bus.req_size;
    assign nbits    = {nbytes, 3'b000};
    assign amask    = OFF_W'(nbytes - 4'd1);
    assign mis      = |(off & amask);
    assign oor      = idx >= ADDR_W'(DEPTH);
    assign bad_size = (bus.req_size == 2'd3) && (DATA_W == 32);
    assign err      = mis | oor | bad_size;
    assign acc      = bus.req_valid && bus.req_ready;

    // Lane enables: size-bytes ones, moved up to the byte offset
    assign lanes = ~({NB{1'b1}} << nbytes);
    assign be    = lanes << off;
    assign wsh   = bus.req_wdata << {off, 3'b000};

    always_ff @(posedge clk) begin
        if (acc && bus.req_we && !err) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wsh[8*i +: 8];
                end
            end
        end
    end

    assign word    = mem[widx];
    assign shifted = word >> {off, 3'b000};
    assign fmask   = ~({DATA_W{1'b1}} << nbits);
    assign msb     = {{(DATA_W-1){1'b0}}, 1'b1} << (nbits - 7'd1);

    always_comb begin
        ext = shifted & fmask;
        if (!bus.req_unsigned && |(shifted & msb)) begin
            ext = shifted | ~fmask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // cnt holds the number of edges since acceptance while in BUSY
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (acc) begin
                    state_d = (READ_LAT == 1) ? RESP : BUSY;
                    cnt_d   = (READ_LAT == 1) ? 3'd0 : 3'd1;
                end
            end
            BUSY: begin
                if (cnt == LAST) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 3'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (acc) begin
            err_q   <= err;
            rdata_q <= (bus.req_we || err) ? '0 : ext;
        end
    end

    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: three configurations, vector table plus
// hand-written backpressure and mid-transaction reset sequences.
module tb_data_mem_lsu;
    typedef struct {
        logic [1:0]  sel;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    localparam int NV = 27;

    logic        clk;
    logic        rst;
    logic [1:0]  sel;
    logic        t_valid;
    logic        t_we;
    logic [1:0]  t_size;
    logic        t_uns;
    logic [31:0] t_addr;
    logic [63:0] t_wdata;
    logic        t_rdy;

    logic        m_req_ready;
    logic        m_rsp_valid;
    logic [63:0] m_rsp_rdata;
    logic        m_rsp_err;

    int   nchk;
    int   nerr;
    int   cyc;
    exp_t sbq[$];
    vec_t vt[NV];

    data_mem_lsu_if #(.DATA_W(32), .ADDR_W(32)) ifa ();
    data_mem_lsu_if #(.DATA_W(32), .ADDR_W(32)) ifb ();
    data_mem_lsu_if #(.DATA_W(64), .ADDR_W(32)) ifc ();

    data_mem_lsu #(
        .DATA_W(32), .DEPTH(32), .ADDR_W(32), .READ_LAT(1)
    ) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));

    data_mem_lsu #(
        .DATA_W(32), .DEPTH(32), .ADDR_W(32), .READ_LAT(3)
    ) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    data_mem_lsu #(
        .DATA_W(64), .DEPTH(32), .ADDR_W(32), .READ_LAT(2)
    ) dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

    assign ifa.req_valid    = t_valid && (sel == 2'd0);
    assign ifa.req_we       = t_we;
    assign ifa.req_size     = t_size;
    assign ifa.req_unsigned = t_uns;
    assign ifa.req_addr     = t_addr;
    assign ifa.req_wdata    = t_wdata[31:0];
    assign ifa.rsp_ready    = t_rdy;

    assign ifb.req_valid    = t_valid && (sel == 2'd1);
    assign ifb.req_we       = t_we;
    assign ifb.req_size     = t_size;
    assign ifb.req_unsigned = t_uns;
    assign ifb.req_addr     = t_addr;
    assign ifb.req_wdata    = t_wdata[31:0];
    assign ifb.rsp_ready    = t_rdy;

    assign ifc.req_valid    = t_valid && (sel == 2'd2);
    assign ifc.req_we       = t_we;
    assign ifc.req_size     = t_size;
    assign ifc.req_unsigned = t_uns;
    assign ifc.req_addr     = t_addr;
    assign ifc.req_wdata    = t_wdata;
    assign ifc.rsp_ready    = t_rdy;

    always_comb begin
        m_req_ready = ifa.req_ready;
        m_rsp_valid = ifa.rsp_valid;
        m_rsp_rdata = 64'(ifa.rsp_rdata);
        m_rsp_err   = ifa.rsp_err;
        case (sel)
            2'd1: begin
                m_req_ready = ifb.req_ready;
                m_rsp_valid = ifb.rsp_valid;
                m_rsp_rdata = 64'(ifb.rsp_rdata);
                m_rsp_err   = ifb.rsp_err;
            end
            2'd2: begin
                m_req_ready = ifc.req_ready;
                m_rsp_valid = ifc.rsp_valid;
                m_rsp_rdata = ifc.rsp_rdata;
                m_rsp_err   = ifc.rsp_err;
            end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [1:0] s);
        case (s)
            2'd0:    return 1;
            2'd1:    return 3;
            default: return 2;
        endcase
    endfunction

    // Response checker: pops the scoreboard on every response handshake
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && m_rsp_valid && t_rdy) begin
            if (sbq.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_rsp: got %h, want none",
                         m_rsp_rdata);
            end else begin
                e = sbq.pop_front();
                chk("rsp_rdata", m_rsp_rdata, e.rdata);
                chk("rsp_err", 64'(m_rsp_err), 64'(e.err));
            end
        end
    end

    task automatic xfer(input vec_t v, input int n);
        int c0;
        bit ok;
        @(posedge clk);
        #1;
        sel     = v.sel;
        t_we    = v.we;
        t_size  = v.size;
        t_uns   = v.uns;
        t_addr  = v.addr;
        t_wdata = v.wdata;
        t_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk($sformatf("accept_timeout_%0d", n), 64'd0, 64'd1);
            t_valid = 1'b0;
            return;
        end
        c0 = cyc;
        sbq.push_back('{v.rdata, v.err});
        @(posedge clk);
        #1;
        t_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk($sformatf("rsp_timeout_%0d", n), 64'd0, 64'd1);
            void'(sbq.pop_back());
            return;
        end
        chk($sformatf("latency_%0d", n), 64'(cyc - c0),
            64'(lat_of(v.sel)));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int c0;
        int seen;
        logic [63:0] hold;

        nchk = 0;
        nerr = 0;
        cyc = 0;
        rst = 1'b1;
        sel = 2'd0;
        t_valid = 1'b0;
        t_we = 1'b0;
        t_size = 2'd0;
        t_uns = 1'b0;
        t_addr = '0;
        t_wdata = '0;
        t_rdy = 1'b1;

        vt[0]  = '{2'd0, 1'b1, 2'd2, 1'b0, 32'h08, 64'h8899AABB, 64'h0, 1'b0};
        vt[1]  = '{2'd0, 1'b0, 2'd0, 1'b1, 32'h0A, 64'h0, 64'h99, 1'b0};
        vt[2]  = '{2'd0, 1'b0, 2'd0, 1'b0, 32'h0A, 64'h0, 64'hFFFFFF99, 1'b0};
        vt[3]  = '{2'd0, 1'b1, 2'd2, 1'b0, 32'h04, 64'h11223344, 64'h0, 1'b0};
        vt[4]  = '{2'd0, 1'b1, 2'd1, 1'b0, 32'h06, 64'hBEEF, 64'h0, 1'b0};
        vt[5]  = '{2'd0, 1'b0, 2'd2, 1'b0, 32'h04, 64'h0, 64'hBEEF3344, 1'b0};
        vt[6]  = '{2'd0, 1'b0, 2'd1, 1'b0, 32'h06, 64'h0, 64'hFFFFBEEF, 1'b0};
        vt[7]  = '{2'd0, 1'b0, 2'd1, 1'b1, 32'h06, 64'h0, 64'h0000BEEF, 1'b0};
        vt[8]  = '{2'd0, 1'b0, 2'd2, 1'b0, 32'h05, 64'h0, 64'h0, 1'b1};
        vt[9]  = '{2'd0, 1'b1, 2'd2, 1'b0, 32'h7C, 64'hDEADBEEF, 64'h0, 1'b0};
        vt[10] = '{2'd0, 1'b1, 2'd2, 1'b0, 32'h80, 64'h12345678, 64'h0, 1'b1};
        vt[11] = '{2'd0, 1'b0, 2'd2, 1'b0, 32'h7C, 64'h0, 64'hDEADBEEF, 1'b0};
        vt[12] = '{2'd0, 1'b0, 2'd3, 1'b0, 32'h00, 64'h0, 64'h0, 1'b1};
        vt[13] = '{2'd0, 1'b1, 2'd0, 1'b0, 32'h0B, 64'hFFFFFF5A, 64'h0, 1'b0};
        vt[14] = '{2'd0, 1'b0, 2'd2, 1'b0, 32'h08, 64'h0, 64'h5A99AABB, 1'b0};
        vt[15] = '{2'd0, 1'b1, 2'd1, 1'b0, 32'h09, 64'h7777, 64'h0, 1'b1};
        vt[16] = '{2'd0, 1'b0, 2'd2, 1'b0, 32'h08, 64'h0, 64'h5A99AABB, 1'b0};
        vt[17] = '{2'd0, 1'b0, 2'd0, 1'b0, 32'h08, 64'h0, 64'hFFFFFFBB, 1'b0};
        vt[18] = '{2'd2, 1'b1, 2'd3, 1'b0, 32'h10,
                   64'h0123456789ABCDEF, 64'h0, 1'b0};
        vt[19] = '{2'd2, 1'b0, 2'd2, 1'b0, 32'h14, 64'h0,
                   64'h0000000001234567, 1'b0};
        vt[20] = '{2'd2, 1'b0, 2'd2, 1'b0, 32'h10, 64'h0,
                   64'hFFFFFFFF89ABCDEF, 1'b0};
        vt[21] = '{2'd2, 1'b0, 2'd1, 1'b1, 32'h16, 64'h0, 64'h0123, 1'b0};
        vt[22] = '{2'd2, 1'b0, 2'd2, 1'b0, 32'h12, 64'h0, 64'h0, 1'b1};
        vt[23] = '{2'd2, 1'b0, 2'd3, 1'b0, 32'h10, 64'h0,
                   64'h0123456789ABCDEF, 1'b0};
        vt[24] = '{2'd2, 1'b1, 2'd2, 1'b0, 32'h100, 64'hCAFEF00D, 64'h0, 1'b1};
        vt[25] = '{2'd1, 1'b1, 2'd2, 1'b0, 32'h20, 64'h0BADCAFE, 64'h0, 1'b0};
        vt[26] = '{2'd1, 1'b0, 2'd2, 1'b0, 32'h20, 64'h0, 64'h0BADCAFE, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready_a", 64'(ifa.req_ready), 64'd0);
        chk("rst_req_ready_b", 64'(ifb.req_ready), 64'd0);
        chk("rst_req_ready_c", 64'(ifc.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(m_rsp_valid), 64'd0);
        chk("rst_rsp_rdata", m_rsp_rdata, 64'd0);
        chk("rst_rsp_err", 64'(m_rsp_err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", 64'(m_req_ready), 64'd1);

        for (int i = 0; i < NV; i++) begin
            xfer(vt[i], i);
        end

        // Backpressure on the 3-cycle configuration
        @(posedge clk);
        #1;
        sel = 2'd1;
        t_we = 1'b0;
        t_size = 2'd2;
        t_uns = 1'b0;
        t_addr = 32'h20;
        t_rdy = 1'b0;
        t_valid = 1'b1;
        @(negedge clk);
        chk("bp_accept_ready", 64'(m_req_ready), 64'd1);
        c0 = cyc;
        sbq.push_back('{64'h0BADCAFE, 1'b0});
        @(posedge clk);
        #1;
        t_valid = 1'b0;
        @(negedge clk);
        chk("bp_valid_c1", 64'(m_rsp_valid), 64'd0);
        @(negedge clk);
        chk("bp_valid_c2", 64'(m_rsp_valid), 64'd0);
        @(negedge clk);
        chk("bp_valid_c3", 64'(m_rsp_valid), 64'd1);
        chk("bp_cycle_c3", 64'(cyc - c0), 64'd3);
        hold = m_rsp_rdata;
        @(posedge clk);
        #1;
        t_we = 1'b1;
        t_wdata = 64'hFFFFFFFF;
        t_valid = 1'b1;
        for (int k = 4; k < 7; k++) begin
            @(negedge clk);
            chk($sformatf("bp_stable_c%0d", k), m_rsp_rdata, hold);
            chk($sformatf("bp_ready_c%0d", k), 64'(m_req_ready), 64'd0);
            chk($sformatf("bp_valid_c%0d", k), 64'(m_rsp_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        t_rdy = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        t_valid = 1'b0;
        t_we = 1'b0;
        @(negedge clk);
        chk("bp_c8_ready", 64'(m_req_ready), 64'd1);
        chk("bp_c8_valid", 64'(m_rsp_valid), 64'd0);
        chk("bp_c8_cycle", 64'(cyc - c0), 64'd8);
        xfer('{2'd1, 1'b0, 2'd2, 1'b0, 32'h20, 64'h0, 64'h0BADCAFE, 1'b0},
             100);

        // Reset while a store is in BUSY
        @(posedge clk);
        #1;
        sel = 2'd1;
        t_we = 1'b1;
        t_size = 2'd2;
        t_addr = 32'h24;
        t_wdata = 64'h13579BDF;
        t_valid = 1'b1;
        @(negedge clk);
        chk("mr_accept_ready", 64'(m_req_ready), 64'd1);
        @(posedge clk);
        #1;
        t_valid = 1'b0;
        t_we = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mr_rsp_valid", 64'(m_rsp_valid), 64'd0);
        chk("mr_req_ready", 64'(m_req_ready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (m_rsp_valid) seen++;
        end
        chk("mr_dropped_rsp", 64'(seen), 64'd0);
        chk("mr_idle_ready", 64'(m_req_ready), 64'd1);
        xfer('{2'd1, 1'b0, 2'd2, 1'b0, 32'h24, 64'h0, 64'h13579BDF, 1'b0},
             101);
        xfer('{2'd1, 1'b0, 2'd2, 1'b0, 32'h20, 64'h0, 64'h0BADCAFE, 1'b0},
             102);

        repeat (3) @(negedge clk);
        chk("sb_drain", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
